// File: rtl/bcd_seg_scanner_pkg.sv
// Shared 7-segment definitions: patterns are {g,f,e,d,c,b,a}, logical active-high.
// Reused by any block that needs to render a BCD digit.
package bcd_seg_scanner_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Non-decimal codes render as a dash so corrupt counter data is visible.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] pat;
    case (bcd)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD digit to 7-segment pattern decoder.
module bcd_seg_decode
  import bcd_seg_scanner_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = bcd_to_seg(bcd_i);
  end

endmodule

// File: rtl/bcd_seg_scanner.sv
// Multiplexed 7-segment scanner: captures packed BCD, swaps it in only at frame
// boundaries, and drives one digit per slot with leading-zero and anti-ghost blanking.
module bcd_seg_scanner
  import bcd_seg_scanner_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_CYC  = 2,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  busy_pend
);

  localparam int PW = $clog2(SCAN_DIV + 1);
  localparam int IW = $clog2(DIGITS);

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   pend_dig_q, pend_dig_d, shown_dig_q, shown_dig_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d, shown_dp_q, shown_dp_d;
  logic                  pend_v_q, pend_v_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [DIGITS-1:0]     an_q, an_d;

  logic                  slot_end, last_slot, blank;
  logic [3:0]            dig_arr [DIGITS];
  logic [DIGITS:0]       lz_run;
  logic [6:0]            dec_seg;

  assign slot_end  = (presc_q == PW'(SCAN_DIV - 1));
  assign last_slot = (idx_q == IW'(DIGITS - 1));

  // lz_run[k]: digits k..DIGITS-1 are all zero with no decimal point requested.
  assign lz_run[DIGITS] = 1'b1;
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign dig_arr[gi] = shown_dig_q[4*gi +: 4];
      assign lz_run[gi]  = lz_run[gi+1] && (dig_arr[gi] == 4'd0) && !shown_dp_q[gi];
    end
  endgenerate

  assign blank = blank_lz && (idx_q != '0) && lz_run[idx_q];

  bcd_seg_decode u_decode (
    .bcd_i (dig_arr[idx_q]),
    .seg_o (dec_seg)
  );

  always_comb begin
    presc_d     = slot_end ? '0 : presc_q + PW'(1);
    idx_d       = idx_q;
    pend_dig_d  = pend_dig_q;
    pend_dp_d   = pend_dp_q;
    pend_v_d    = pend_v_q;
    shown_dig_d = shown_dig_q;
    shown_dp_d  = shown_dp_q;

    if (slot_end) begin
      idx_d = last_slot ? '0 : idx_q + IW'(1);
    end
    // Transfer first so a coincident load re-arms pending with the newer data.
    if (slot_end && last_slot && pend_v_q) begin
      shown_dig_d = pend_dig_q;
      shown_dp_d  = pend_dp_q;
      pend_v_d    = 1'b0;
    end
    if (load) begin
      pend_dig_d = digits_in;
      pend_dp_d  = dp_in;
      pend_v_d   = 1'b1;
    end

    seg_d = blank ? SEG_OFF : dec_seg;
    dp_d  = blank ? 1'b0 : shown_dp_q[idx_q];
    an_d  = (presc_q < PW'(BLANK_CYC)) ? '0 : (DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      presc_q     <= '0;
      idx_q       <= '0;
      pend_dig_q  <= '0;
      pend_dp_q   <= '0;
      pend_v_q    <= 1'b0;
      shown_dig_q <= '0;
      shown_dp_q  <= '0;
      seg_q       <= '0;
      dp_q        <= 1'b0;
      an_q        <= '0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      pend_dig_q  <= pend_dig_d;
      pend_dp_q   <= pend_dp_d;
      pend_v_q    <= pend_v_d;
      shown_dig_q <= shown_dig_d;
      shown_dp_q  <= shown_dp_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
    end
  end

  assign seg       = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign dp        = (ACTIVE_LOW != 0) ? ~dp_q  : dp_q;
  assign an        = (ACTIVE_LOW != 0) ? ~an_q  : an_q;
  assign busy_pend = pend_v_q;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Directed self-checking bench for bcd_seg_scanner with DIGITS=4, SCAN_DIV=4, BLANK_CYC=1.
module tb_bcd_seg_scanner;

  localparam logic [6:0] S0 = 7'h3F, S1 = 7'h06, S2 = 7'h5B, S3 = 7'h4F, S4 = 7'h66;
  localparam logic [6:0] S5 = 7'h6D, S6 = 7'h7D, S7 = 7'h07, S8 = 7'h7F, S9 = 7'h6F;
  localparam logic [6:0] SD = 7'h40, SX = 7'h00;

  logic        clk = 1'b0;
  logic        clr, load, blank_lz, dp, busy_pend;
  logic [15:0] digits_in;
  logic [3:0]  dp_in, an;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;
  // Bench-side scan position: st_* is the DUT state after the last edge,
  // out_* is the state the registered outputs currently represent.
  int st_p = 0, st_i = 0, out_p = 0, out_i = 0;

  always #5 clk = ~clk;

  bcd_seg_scanner #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .ACTIVE_LOW(0)) dut (
    .clk       (clk),
    .clr       (clr),
    .digits_in (digits_in),
    .load      (load),
    .dp_in     (dp_in),
    .blank_lz  (blank_lz),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .busy_pend (busy_pend)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    out_p = st_p;
    out_i = st_i;
    if (clr) begin
      st_p = 0;
      st_i = 0;
    end else if (st_p == 3) begin
      st_p = 0;
      st_i = (st_i == 3) ? 0 : st_i + 1;
    end else begin
      st_p++;
    end
    #1;
  endtask

  task automatic goto_st(input int p, input int i);
    for (int n = 0; n < 40 && !(st_p == p && st_i == i); n++) tick();
  endtask

  task automatic load_val(input logic [15:0] val, input logic [3:0] dps);
    digits_in = val;
    dp_in     = dps;
    load      = 1'b1;
    tick();
    load      = 1'b0;
  endtask

  // segs packs expected digit patterns as {d3,d2,d1,d0}.
  task automatic check_frame(input string name, input logic [27:0] segs, input logic [3:0] dps);
    logic [3:0] exp_an;
    goto_st(0, 0);
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 4; p++) begin
        tick();
        exp_an = (p == 0) ? 4'b0000 : (4'b0001 << k);
        $display("frame %s digit %0d phase %0d: an=%b seg=%h dp=%b", name, k, p, an, seg, dp);
        chk($sformatf("%s_an_d%0d_p%0d", name, k, p), 32'(an), 32'(exp_an));
        chk($sformatf("%s_seg_d%0d_p%0d", name, k, p), 32'(seg), 32'(segs[k*7 +: 7]));
        chk($sformatf("%s_dp_d%0d_p%0d", name, k, p), 32'(dp), 32'(dps[k]));
      end
    end
  endtask

  initial begin
    clr = 1'b1; load = 1'b0; blank_lz = 1'b0; digits_in = '0; dp_in = '0;

    // Reset
    repeat (3) tick();
    chk("rst_seg", 32'(seg), 32'(SX));
    chk("rst_an", 32'(an), 32'h0);
    chk("rst_dp", 32'(dp), 32'h0);
    chk("rst_busy", 32'(busy_pend), 32'h0);
    clr = 1'b0;
    tick();
    chk("rel_an_first", 32'(an), 32'h0);
    tick();
    chk("rel_an_second", 32'(an), 32'h1);

    // Scan 1234
    load_val(16'h1234, 4'b0000);
    chk("scan_busy_set", 32'(busy_pend), 32'h1);
    goto_st(3, 3);
    chk("scan_busy_hold", 32'(busy_pend), 32'h1);
    tick();
    chk("scan_busy_fall", 32'(busy_pend), 32'h0);
    check_frame("f1234", {S1, S2, S3, S4}, 4'b0000);

    // Tearing: load 5678 mid digit-2 slot
    goto_st(1, 2);
    load_val(16'h5678, 4'b0000);
    chk("tear_busy_set", 32'(busy_pend), 32'h1);
    while (!(st_p == 3 && st_i == 3)) begin
      tick();
      chk($sformatf("tear_old_seg_d%0d", out_i), 32'(seg), 32'((out_i == 2) ? S2 : S1));
    end
    chk("tear_busy_before", 32'(busy_pend), 32'h1);
    tick();
    chk("tear_last_old_seg", 32'(seg), 32'(S1));
    chk("tear_busy_fall", 32'(busy_pend), 32'h0);
    check_frame("f5678", {S5, S6, S7, S8}, 4'b0000);

    // Boundary collision: 0912 pending, 9999 loaded on the transfer cycle
    load_val(16'h0912, 4'b0000);
    goto_st(3, 3);
    load_val(16'h9999, 4'b0000);
    chk("coll_busy_stays", 32'(busy_pend), 32'h1);
    check_frame("f0912", {S0, S9, S1, S2}, 4'b0000);
    chk("coll_busy_after", 32'(busy_pend), 32'h0);
    check_frame("f9999", {S9, S9, S9, S9}, 4'b0000);

    // Leading-zero blanking
    blank_lz = 1'b1;
    load_val(16'h0070, 4'b0000);
    check_frame("lz0070", {SX, SX, S7, S0}, 4'b0000);
    load_val(16'h0000, 4'b0000);
    check_frame("lz0000", {SX, SX, SX, S0}, 4'b0000);
    load_val(16'h0000, 4'b0100);
    check_frame("lzdp", {SX, S0, S0, S0}, 4'b0100);

    // Invalid BCD
    load_val(16'h00AF, 4'b0000);
    check_frame("inv00AF", {SX, SX, SD, SD}, 4'b0000);

    // Clear mid-frame discards pending data
    load_val(16'h1111, 4'b0000);
    chk("clr_busy_before", 32'(busy_pend), 32'h1);
    goto_st(1, 2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_seg", 32'(seg), 32'(SX));
    chk("clr_an", 32'(an), 32'h0);
    chk("clr_dp", 32'(dp), 32'h0);
    chk("clr_busy", 32'(busy_pend), 32'h0);
    tick();
    chk("clr_restart_an0", 32'(an), 32'h0);
    chk("clr_restart_seg", 32'(seg), 32'(S0));
    tick();
    chk("clr_restart_an1", 32'(an), 32'h1);
    check_frame("postclr", {SX, SX, SX, S0}, 4'b0000);
    chk("postclr_busy", 32'(busy_pend), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
